// File: rtl/image_link_pkg.sv
// Shared definitions for the image link: FSM state encoding (common with the
// sender side) and the packed RGB pixel type.
package image_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_R = 3'd1,
        ST_GET_G = 3'd2,
        ST_GET_B = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd7
    } link_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/rx_byte_strobe.sv
// Rising-edge detector on the UART rxDone level: one strobe per received byte,
// no matter how long rxDone stays high.
module rx_byte_strobe (
    input  logic clk,
    input  logic rst,
    input  logic rx_done,
    output logic byte_stb
);

    logic rx_done_q;

    // Delayed copy of rxDone for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_done_q <= 1'b0;
        else     rx_done_q <= rx_done;
    end

    assign byte_stb = rx_done && !rx_done_q;

endmodule

// File: rtl/image_receiver.sv
// Assembles R,G,B byte triplets from the UART receiver into 24-bit pixels and
// hands them to the SDRAM write FIFO through a one-deep valid/ready register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | rdy high, waiting for en
// GET_R    | collecting R byte (output register may still be pending)
// GET_G    | collecting G byte
// GET_B    | collecting B byte, then load the output register
// DRAIN    | last pixel loaded, waiting for the FIFO to take it
// DONE     | one-cycle done pulse
// ERR      | aborted frame (rxErr, overflow or en dropped); wait for en=0
module image_receiver
    import image_link_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic        done,
    output logic        err,
    output logic        rxEn,
    input  logic [7:0]  rx_data,
    input  logic        rxDone,
    input  logic        rxErr,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int FRAME = WIDTH * HEIGHT;
    localparam int CW    = $clog2(FRAME + 1);

    link_state_t   state;
    pixel_t        rgb_q;
    logic [CW-1:0] pix_cnt;
    logic          byte_stb;
    logic          accept;
    logic [CW:0]   loaded;
    logic          last_pix;

    rx_byte_strobe u_stb (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rxDone),
        .byte_stb (byte_stb)
    );

    assign accept = pix_valid && pix_ready;

    // Pixels already handed over or still pending; the one being loaded is
    // the last when this equals FRAME-1.
    assign loaded   = {1'b0, pix_cnt} + {{CW{1'b0}}, pix_valid};
    assign last_pix = (loaded == (CW+1)'(FRAME - 1));

    // Frame FSM with registered handshake outputs, pixel counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rdy       <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rxEn      <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_cnt   <= '0;
            rgb_q     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                pix_valid <= 1'b0;
                pix_cnt   <= pix_cnt + CW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_GET_R;
                        rdy     <= 1'b0;
                        rxEn    <= 1'b1;
                        pix_cnt <= '0;
                    end
                end
                ST_GET_R, ST_GET_G, ST_GET_B: begin
                    if (rxErr || !en) begin
                        state     <= ST_ERR;
                        err       <= 1'b1;
                        rxEn      <= 1'b0;
                        pix_valid <= 1'b0;
                    end else if (byte_stb) begin
                        if (state == ST_GET_R) begin
                            rgb_q.r <= rx_data;
                            state   <= ST_GET_G;
                        end else if (state == ST_GET_G) begin
                            rgb_q.g <= rx_data;
                            state   <= ST_GET_B;
                        end else if (pix_valid && !pix_ready) begin
                            // Output register still full: the pending pixel is dropped.
                            state     <= ST_ERR;
                            err       <= 1'b1;
                            rxEn      <= 1'b0;
                            pix_valid <= 1'b0;
                        end else begin
                            pix_data  <= {rgb_q.r, rgb_q.g, rx_data};
                            pix_valid <= 1'b1;
                            if (last_pix) begin
                                state <= ST_DRAIN;
                                rxEn  <= 1'b0;
                            end else begin
                                state <= ST_GET_R;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b1;
                end
                ST_ERR: begin
                    pix_valid <= 1'b0;
                    if (!en) begin
                        state <= ST_IDLE;
                        err   <= 1'b0;
                        rdy   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b1;
                    rxEn  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver with a 2x1 frame; UART bytes are driven
// directly on rx_data/rxDone.
module tb_image_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy, done, err, rxEn;
    logic [7:0]  rx_data;
    logic        rxDone;
    logic        rxErr;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    int checks = 0;
    int fails  = 0;

    logic [23:0] acc_q[$];
    int          done_cnt  = 0;
    int          valid_cyc = 0;

    image_receiver #(.WIDTH(2), .HEIGHT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .done      (done),
        .err       (err),
        .rxEn      (rxEn),
        .rx_data   (rx_data),
        .rxDone    (rxDone),
        .rxErr     (rxErr),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    always #5 clk = ~clk;

    // Record transfers, done pulses and valid-high cycles.
    always @(posedge clk) begin
        if (pix_valid && pix_ready) acc_q.push_back(pix_data);
        if (done) done_cnt++;
        if (pix_valid) valid_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit drop_en);
        @(negedge clk);
        rx_data = b;
        rxDone  = 1'b1;
        @(negedge clk);
        if (drop_en) en = 1'b0;
        repeat (hold - 1) @(negedge clk);
        rxDone = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   32'(rdy),       32'd1);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
        check({tag, "_rxen"},  32'(rxEn),      32'd0);
        check({tag, "_pdata"}, 32'(pix_data),  32'd0);
        check({tag, "_pval"},  32'(pix_valid), 32'd0);
    endtask

    initial begin
        int base, dbase, vbase;
        bit got;

        rst = 1'b1; en = 1'b0; rx_data = 8'h00; rxDone = 1'b0; rxErr = 1'b0; pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: straight frame, FIFO always ready
        base = acc_q.size(); dbase = done_cnt; vbase = valid_cyc;
        en = 1'b1;
        @(negedge clk);
        check("t1_rxen_after_en", 32'(rxEn), 32'd1);
        check("t1_rdy_after_en",  32'(rdy),  32'd0);
        send_byte(8'h11, 3, 0); send_byte(8'h22, 3, 0); send_byte(8'h33, 3, 0);
        send_byte(8'h44, 3, 0); send_byte(8'h55, 3, 0); send_byte(8'h66, 3, 1);
        check("t1_npix",     32'(acc_q.size() - base), 32'd2);
        check("t1_pix0",     32'(acc_q[base]),         32'h112233);
        check("t1_pix1",     32'(acc_q[base + 1]),     32'h445566);
        check("t1_done_cnt", 32'(done_cnt - dbase),    32'd1);
        check("t1_valid_cyc",32'(valid_cyc - vbase),   32'd2);
        check("t1_rdy",      32'(rdy),                 32'd1);
        check("t1_err",      32'(err),                 32'd0);

        // 2: FIFO stalls until the 5th byte
        base = acc_q.size(); dbase = done_cnt;
        pix_ready = 1'b0; en = 1'b1;
        send_byte(8'h11, 3, 0); send_byte(8'h22, 3, 0); send_byte(8'h33, 3, 0);
        send_byte(8'h44, 3, 0);
        check("t2_held_valid", 32'(pix_valid), 32'd1);
        check("t2_held_data",  32'(pix_data),  32'h112233);
        pix_ready = 1'b1;
        send_byte(8'h55, 3, 0); send_byte(8'h66, 3, 1);
        check("t2_npix",     32'(acc_q.size() - base), 32'd2);
        check("t2_pix0",     32'(acc_q[base]),         32'h112233);
        check("t2_pix1",     32'(acc_q[base + 1]),     32'h445566);
        check("t2_done_cnt", 32'(done_cnt - dbase),    32'd1);
        check("t2_err",      32'(err),                 32'd0);
        check("t2_rdy",      32'(rdy),                 32'd1);

        // 3: FIFO never ready -> overflow on second pixel's B byte
        base = acc_q.size(); dbase = done_cnt;
        pix_ready = 1'b0; en = 1'b1;
        send_byte(8'h11, 3, 0); send_byte(8'h22, 3, 0); send_byte(8'h33, 3, 0);
        send_byte(8'h44, 3, 0); send_byte(8'h55, 3, 0);
        check("t3_err_before", 32'(err), 32'd0);
        send_byte(8'h66, 3, 0);
        check("t3_err",      32'(err),       32'd1);
        check("t3_rxen",     32'(rxEn),      32'd0);
        check("t3_pval",     32'(pix_valid), 32'd0);
        check("t3_rdy",      32'(rdy),       32'd0);
        en = 1'b0;
        @(negedge clk);
        check("t3_err_clr",  32'(err), 32'd0);
        check("t3_rdy_back", 32'(rdy), 32'd1);
        check("t3_npix",     32'(acc_q.size() - base), 32'd0);
        check("t3_done_cnt", 32'(done_cnt - dbase),    32'd0);

        // 4: framing error after the G byte
        base = acc_q.size(); vbase = valid_cyc;
        pix_ready = 1'b1; en = 1'b1;
        send_byte(8'h11, 3, 0); send_byte(8'h22, 3, 0);
        @(negedge clk);
        rxErr = 1'b1;
        @(negedge clk);
        check("t4_err",  32'(err),       32'd1);
        check("t4_rxen", 32'(rxEn),      32'd0);
        check("t4_pval", 32'(pix_valid), 32'd0);
        rxErr = 1'b0;
        send_byte(8'h33, 3, 0);
        check("t4_err_hold",  32'(err), 32'd1);
        check("t4_no_valid",  32'(valid_cyc - vbase), 32'd0);
        en = 1'b0;
        @(negedge clk);
        check("t4_idle_rdy", 32'(rdy), 32'd1);
        check("t4_npix",     32'(acc_q.size() - base), 32'd0);

        // 5: reset mid-frame after the first pixel is accepted, then a clean frame
        base = acc_q.size();
        en = 1'b1;
        send_byte(8'hA1, 3, 0); send_byte(8'hA2, 3, 0);
        @(negedge clk);
        rx_data = 8'hA3; rxDone = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (acc_q.size() > base) got = 1'b1;
        end
        check("t5_first_accept", 32'(got), 32'd1);
        check("t5_first_pix",    32'(acc_q[base]), 32'hA1A2A3);
        rxDone = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        base = acc_q.size(); dbase = done_cnt;
        @(negedge clk);
        check("t5_rxen_restart", 32'(rxEn), 32'd1);
        send_byte(8'h11, 3, 0); send_byte(8'h22, 3, 0); send_byte(8'h33, 3, 0);
        send_byte(8'h44, 3, 0); send_byte(8'h55, 3, 0); send_byte(8'h66, 3, 1);
        check("t5_npix",     32'(acc_q.size() - base), 32'd2);
        check("t5_pix0",     32'(acc_q[base]),         32'h112233);
        check("t5_pix1",     32'(acc_q[base + 1]),     32'h445566);
        check("t5_done_cnt", 32'(done_cnt - dbase),    32'd1);

        // 6: rxDone held high for 100 cycles yields a single byte
        base = acc_q.size(); dbase = done_cnt;
        en = 1'b1;
        send_byte(8'hAA, 100, 0); send_byte(8'hBB, 3, 0); send_byte(8'hCC, 3, 0);
        send_byte(8'hDD, 3, 0);   send_byte(8'hEE, 3, 0); send_byte(8'hFF, 3, 1);
        check("t6_npix",     32'(acc_q.size() - base), 32'd2);
        check("t6_pix0",     32'(acc_q[base]),         32'hAABBCC);
        check("t6_pix1",     32'(acc_q[base + 1]),     32'hDDEEFF);
        check("t6_done_cnt", 32'(done_cnt - dbase),    32'd1);
        check("t6_rdy",      32'(rdy),                 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
